// File: rtl/lti_dac_pkg.sv
// Shared types and frame builder for the LTI controller's SPI DAC writer.
// Build option: LTI_DAC_OFFSET_BINARY_EN flips the sample MSB at capture.
package lti_dac_pkg;

    localparam int DAC_DW    = 16;
    localparam int DAC_CMD_W = 8;
    localparam int DAC_FW    = DAC_CMD_W + DAC_DW;

    localparam logic [DAC_CMD_W-1:0] DAC_CMD = 8'h03;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } dac_state_e;

    function automatic logic [DAC_FW-1:0] lti_dac_frame(
        input logic [DAC_CMD_W-1:0] cmd,
        input logic [DAC_DW-1:0]    s
    );
`ifdef LTI_DAC_OFFSET_BINARY_EN
        // Two's complement to offset binary for unipolar converters.
        return {cmd, ~s[DAC_DW-1], s[DAC_DW-2:0]};
`else
        return {cmd, s};
`endif
    endfunction

endpackage

// File: rtl/lti_dac_spi_writer_timer.sv
// Phase and bit counters for one SPI mode-0 frame; generates sclk and
// the strobes that advance the shifter and close the frame.
module spi_bit_timer
    import lti_dac_pkg::*;
#(
    parameter int FW      = DAC_FW,
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic sclk,
    output logic bit_start,
    output logic frame_end
);

    localparam int PH_W  = $clog2(2 * CLK_DIV);
    localparam int BIT_W = $clog2(FW);

    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_HIGH  = PH_W'(CLK_DIV);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FW - 1);

    logic             r_active;
    logic [PH_W-1:0]  r_phase;
    logic [BIT_W-1:0] r_bit;
    logic             w_ph_last;

    assign w_ph_last = r_active && (r_phase == PH_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_phase  <= '0;
            r_bit    <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_phase  <= '0;
            r_bit    <= '0;
        end else if (w_ph_last) begin
            r_phase <= '0;
            if (r_bit == BIT_LAST) begin
                r_active <= 1'b0;
            end else begin
                r_bit <= r_bit + 1'b1;
            end
        end else if (r_active) begin
            r_phase <= r_phase + 1'b1;
        end
    end

    // bit_start fires on the edge that opens the next bit period.
    assign sclk      = r_active && (r_phase >= PH_HIGH);
    assign bit_start = w_ph_last && (r_bit != BIT_LAST);
    assign frame_end = w_ph_last && (r_bit == BIT_LAST);

endmodule

// File: rtl/lti_dac_spi_writer.sv
// SPI DAC writer: {CMD, sample} frames, one-deep holding slot, overrun flag.
// Build option: LTI_DAC_OFFSET_BINARY_EN (see lti_dac_pkg).
module lti_dac_spi_writer
    import lti_dac_pkg::*;
#(
    parameter int                 DW      = DAC_DW,
    parameter int                 CMD_W   = DAC_CMD_W,
    parameter logic [CMD_W-1:0]   CMD     = DAC_CMD,
    parameter int                 FW      = CMD_W + DW,
    parameter int                 CLK_DIV = 2,
    parameter int                 GAP_CYC = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] sig_in,
    input  logic          ce_in,
    input  logic          clear_overrun,
    output logic          sclk,
    output logic          mosi,
    output logic          cs_n,
    output logic          busy,
    output logic          done,
    output logic          overrun
);

    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    dac_state_e       r_state;
    logic [FW-1:0]    r_shift;
    logic [DW-1:0]    r_hold;
    logic             r_pending;
    logic             r_overrun;
    logic             r_done;
    logic [GAP_W-1:0] r_gap;

    logic w_gap_last;
    logic w_load_hold;
    logic w_gap_direct;
    logic w_hold_wr;
    logic w_ovr_set;
    logic w_start;
    logic w_bit_start;
    logic w_frame_end;

    assign w_gap_last   = (r_state == GAP) && (r_gap == GAP_LAST);
    assign w_load_hold  = w_gap_last && r_pending;
    // Empty slot at the end of the gap: start straight from sig_in.
    assign w_gap_direct = w_gap_last && !r_pending && ce_in;
    assign w_hold_wr    = ce_in && (r_state != IDLE) && !w_gap_direct;
    assign w_ovr_set    = w_hold_wr && r_pending && !w_load_hold;
    assign w_start      = ((r_state == IDLE) && ce_in)
                        || w_load_hold || w_gap_direct;

    spi_bit_timer #(
        .FW      (FW),
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .start     (w_start),
        .sclk      (sclk),
        .bit_start (w_bit_start),
        .frame_end (w_frame_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_gap   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= (r_state == SHIFT) && w_frame_end;
            unique case (r_state)
                IDLE: begin
                    if (ce_in) begin
                        r_state <= SHIFT;
                        r_shift <= lti_dac_frame(CMD, sig_in);
                    end
                end
                SHIFT: begin
                    if (w_frame_end) begin
                        r_state <= GAP;
                        r_gap   <= '0;
                    end else if (w_bit_start) begin
                        r_shift <= {r_shift[FW-2:0], 1'b0};
                    end
                end
                GAP: begin
                    if (w_load_hold) begin
                        r_state <= SHIFT;
                        r_shift <= lti_dac_frame(CMD, r_hold);
                    end else if (w_gap_direct) begin
                        r_state <= SHIFT;
                        r_shift <= lti_dac_frame(CMD, sig_in);
                    end else if (w_gap_last) begin
                        r_state <= IDLE;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold    <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_hold_wr) begin
                r_hold <= sig_in;
            end
            if (w_load_hold) begin
                r_pending <= ce_in;
            end else if (w_hold_wr) begin
                r_pending <= 1'b1;
            end
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (clear_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign busy    = (r_state != IDLE);
    assign cs_n    = (r_state != SHIFT);
    assign mosi    = (r_state == SHIFT) && r_shift[FW-1];
    assign done    = r_done;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_lti_dac_spi_writer.sv
// Directed bench for lti_dac_spi_writer: vector table of single frames
// plus sequences for reset, back-to-back, overrun and gap boundary.
module tb_lti_dac_spi_writer;

`ifdef LTI_DAC_OFFSET_BINARY_EN
    localparam bit OB = 1'b1;
`else
    localparam bit OB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] sig_in = '0;
    logic        ce_in = 1'b0;
    logic        clear_overrun = 1'b0;
    logic        sclk, mosi, cs_n, busy, done, overrun;

    int checks = 0;
    int errors = 0;

    logic [23:0] cap = '0;
    int          nrise = 0;
    logic [23:0] fq[$];
    int          rq[$];

    typedef struct {
        logic [15:0] sig;
        logic [23:0] exp_tc;
        logic [23:0] exp_ob;
    } vec_t;

    vec_t vecs[6];

    lti_dac_spi_writer dut (
        .clk           (clk),
        .rst           (rst),
        .sig_in        (sig_in),
        .ce_in         (ce_in),
        .clear_overrun (clear_overrun),
        .sclk          (sclk),
        .mosi          (mosi),
        .cs_n          (cs_n),
        .busy          (busy),
        .done          (done),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge sclk) begin
        cap = {cap[22:0], mosi};
        nrise++;
    end

    always @(posedge cs_n) begin
        fq.push_back(cap);
        rq.push_back(nrise);
        cap = '0;
        nrise = 0;
    end

    function automatic logic [23:0] model(input logic [15:0] s);
        return {8'h03, s[15] ^ OB, s[14:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [15:0] s);
        sig_in = s;
        ce_in  = 1'b1;
        adv(1);
        ce_in  = 1'b0;
    endtask

    task automatic flush();
        fq.delete();
        rq.delete();
        cap = '0;
        nrise = 0;
    endtask

    task automatic get_frame(input string name, input logic [23:0] exp);
        int t = 0;
        while (fq.size() == 0 && t < 400) begin
            adv(1);
            t++;
        end
        chk({name, "_timeout"}, (fq.size() != 0), 1);
        if (fq.size() != 0) begin
            chk({name, "_frame"}, fq.pop_front(), exp);
            chk({name, "_rises"}, rq.pop_front(), 24);
        end
    endtask

    task automatic run_single(input string name, input logic [15:0] s,
                              input logic [23:0] exp);
        int first = -1, last = -1, nlow = 0, ndone = 0, done_c = -1;
        logic m1 = 1'b0, b99 = 1'b1;
        pulse(s);
        for (int c = 1; c <= 99; c++) begin
            @(negedge clk);
            if (!cs_n) begin
                if (first < 0) first = c;
                last = c;
                nlow++;
            end
            if (c == 1) m1 = mosi;
            if (done) begin
                ndone++;
                done_c = c;
            end
            if (c == 99) b99 = busy;
        end
        chk({name, "_cs_first"}, first, 1);
        chk({name, "_cs_last"}, last, 96);
        chk({name, "_cs_count"}, nlow, 96);
        chk({name, "_mosi_c1"}, m1, exp[23]);
        chk({name, "_done_n"}, ndone, 1);
        chk({name, "_done_cyc"}, done_c, 97);
        chk({name, "_busy99"}, b99, 0);
        get_frame(name, exp);
    endtask

    initial begin
        vecs[0] = '{16'h8001, 24'h038001, 24'h030001};
        vecs[1] = '{16'h7FFF, 24'h037FFF, 24'h03FFFF};
        vecs[2] = '{16'h0000, 24'h030000, 24'h038000};
        vecs[3] = '{16'hFFFF, 24'h03FFFF, 24'h037FFF};
        vecs[4] = '{16'h1234, 24'h031234, 24'h039234};
        vecs[5] = '{16'hA5A5, 24'h03A5A5, 24'h0325A5};

        #2 rst = 1'b1;
        #1;
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        adv(2);
        rst = 1'b0;
        adv(2);
        flush();
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 6; i++) begin
            run_single($sformatf("vec%0d", i), vecs[i].sig,
                       OB ? vecs[i].exp_ob : vecs[i].exp_tc);
        end

        // Async reset in the middle of a frame.
        adv(4);
        pulse(16'h5A5A);
        adv(39);
        chk("pre_rst_sclk", sclk, 1);
        chk("pre_rst_cs_n", cs_n, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_cs_n", cs_n, 1);
        chk("mid_rst_sclk", sclk, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mosi", mosi, 0);
        adv(2);
        rst = 1'b0;
        adv(1);
        flush();
        run_single("post_rst", 16'h8001, model(16'h8001));

        // Back-to-back: second sample while first is in flight.
        adv(4);
        pulse(16'h8001);
        adv(49);
        pulse(16'h1234);
        adv(47);
        @(negedge clk);
        chk("b2b_cs_c98", cs_n, 1);
        @(negedge clk);
        chk("b2b_cs_c99", cs_n, 0);
        get_frame("b2b_a", model(16'h8001));
        get_frame("b2b_b", model(16'h1234));
        chk("b2b_overrun", overrun, 0);

        // Overrun: newest pending sample wins.
        adv(4);
        pulse(16'h0F0F);
        adv(29);
        pulse(16'h1111);
        chk("ovr_before", overrun, 0);
        adv(29);
        pulse(16'h2222);
        chk("ovr_set", overrun, 1);
        get_frame("ovr_a", model(16'h0F0F));
        get_frame("ovr_b", model(16'h2222));
        adv(4);
        clear_overrun = 1'b1;
        adv(1);
        clear_overrun = 1'b0;
        chk("ovr_clear", overrun, 0);

        // Clear coinciding with a fresh overwrite: set wins.
        pulse(16'h4444);
        adv(9);
        pulse(16'h5555);
        adv(9);
        sig_in = 16'h6666;
        ce_in = 1'b1;
        clear_overrun = 1'b1;
        adv(1);
        ce_in = 1'b0;
        clear_overrun = 1'b0;
        chk("ovr_set_wins", overrun, 1);
        get_frame("ovr_c", model(16'h4444));
        get_frame("ovr_d", model(16'h6666));
        adv(4);
        clear_overrun = 1'b1;
        adv(1);
        clear_overrun = 1'b0;
        chk("ovr_clear2", overrun, 0);

        // ce_in on the last gap cycle with a sample already pending.
        pulse(16'hAAAA);
        adv(49);
        pulse(16'hBBBB);
        adv(47);
        pulse(16'hCCCC);
        chk("gap_edge_ovr", overrun, 0);
        get_frame("gap_a", model(16'hAAAA));
        get_frame("gap_b", model(16'hBBBB));
        get_frame("gap_c", model(16'hCCCC));
        chk("gap_edge_ovr_end", overrun, 0);
        adv(4);
        chk("final_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lti_dac_spi_writer.md
Name: lti_dac_spi_writer

Overview:
Downstream stage of the delta-operator LTI controller. It captures each output sample on the controller's `ce_out` pulse and serialises it, with a fixed command prefix, to an external SPI DAC (mode 0, MSB first). A one-deep holding register absorbs a sample that arrives while a frame is in flight. A sticky overrun flag reports lost samples.

Parameters:
- DW, 16, sample width; matches the controller's OW.
- CMD_W, 8, command prefix width.
- CMD, 8'h03, command prefix sent before every sample.
- FW, CMD_W+DW, total frame bits (derived; do not override).
- CLK_DIV, 2, clk cycles per SCLK half-period; must be ≥1.
- GAP_CYC, 2, minimum clk cycles cs_n is held high between frames; must be ≥1.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst, input, 1, asynchronous active-high reset.
- sig_in, input, DW, signed sample (the controller's sig_out_1).
- ce_in, input, 1, one-cycle sample strobe (the controller's ce_out).
- clear_overrun, input, 1, synchronous clear of the overrun flag.
- sclk, output, 1, SPI clock; idles low.
- mosi, output, 1, SPI data.
- cs_n, output, 1, SPI chip select, active low.
- busy, output, 1, high whenever state ≠ IDLE.
- done, output, 1, one-cycle pulse when a frame's last bit completes.
- overrun, output, 1, sticky: a pending sample was overwritten.

Behaviour:
- Reset (async, any time, including mid-frame): frame aborts immediately.
  - Outputs: cs_n=1, sclk=0, mosi=0, busy=0, done=0, overrun=0.
  - State is IDLE; holding register and pending bit are cleared.
- States:
  - IDLE → SHIFT on ce_in. sig_in is captured into the shift register as {CMD, sig_in}.
  - SHIFT → GAP after bit FW-1 completes its high phase.
  - GAP → SHIFT after GAP_CYC cycles if pending=1. The holding register loads into the shift register and pending clears.
  - GAP → IDLE after GAP_CYC cycles otherwise.
- Latency: ce_in at cycle 0 in IDLE gives cs_n=0 and mosi=frame[FW-1] from cycle 1.
- Bit timing:
  - Each bit lasts 2·CLK_DIV cycles: CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1.
  - mosi changes only at the start of a bit period, i.e. while sclk is low.
  - cs_n stays low for exactly FW·2·CLK_DIV cycles.
- done pulses in the first GAP cycle. cs_n=1 and sclk=0 throughout GAP.
- ce_in while state ≠ IDLE: sig_in is written to the holding register.
  - If pending=0, pending is set.
  - If pending=1, the new sample replaces the old one and overrun is set. Newest sample wins.
- Simultaneous events:
  - ce_in on the last GAP cycle with pending=1: the holding sample moves to the shift register, the new sample enters the holding register, and pending stays 1. No overrun.
  - clear_overrun together with a new overrun event: overrun stays 1 (set wins).
- ce_in in IDLE never touches the holding register.
- Counters:
  - Bit counter is $clog2(FW) bits wide.
  - Phase counter is $clog2(2·CLK_DIV) bits wide.
  - Counters wrap only through explicit reload; no free-running wrap.

Optional Feature:
- Macro: LTI_DAC_OFFSET_BINARY_EN.
- Defined: the sample MSB is inverted at capture (both direct and holding paths). This converts two's complement to offset binary for unipolar DACs.
- Undefined: the sample is sent unmodified as two's complement.

Decomposition:
- Package lti_dac_pkg holds:
  - the state enum (IDLE, SHIFT, GAP);
  - default CMD and CMD_W constants;
  - a function returning the captured frame, which applies the offset-binary transform when the macro is set.
- One sub-module, spi_bit_timer, owns the phase and bit counters.
  - Outputs: sclk, bit_start and frame_end strobes.
  - Inputs: start and rst.

Test Plan:
- Reset check: assert rst mid-frame (cycle 40 of 96) → cs_n=1, sclk=0, busy=0 in the same cycle, before the next clk edge; after deassert, ce_in starts a fresh full frame.
- Single sample: sig_in=16'h8001, CLK_DIV=2 → cs_n low cycles 1–96, 24 rising sclk edges, mosi sampled on rising edges = 0x038001, done pulse at cycle 97, busy=0 at cycle 99.
- Back-to-back: second ce_in (16'h1234) at cycle 50 → pending; second frame cs_n falls at cycle 99, sends 0x031234, overrun=0.
- Overrun: ce_in with 16'h1111 at cycle 30, then 16'h2222 at cycle 60 → overrun=1; next frame sends 0x032222; clear_overrun drops the flag; clear_overrun coinciding with a third overwrite leaves overrun=1.
- Boundary: ce_in on the last GAP cycle with pending already set → no overrun; both samples transmitted in order.
- With LTI_DAC_OFFSET_BINARY_EN: sig_in=16'h8001 → 0x030001 transmitted; sig_in=16'h7FFF → 0x03FFFF.
